// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester ports and memory-side bus of the two-port memory arbiter.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_enable;
    logic        mem_rw;
    logic [31:0] mem_ain;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        busy;
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_dout,
        output if_ack, if_rdata, if_err, d_ack, d_rdata, d_err,
               mem_enable, mem_rw, mem_ain, mem_din, busy
    );
    modport master (
        output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_dout,
        input  if_ack, if_rdata, if_err, d_ack, d_rdata, d_err,
               mem_enable, mem_rw, mem_ain, mem_din, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin fetch/data arbiter and sequencer for a single-port word memory,
// with byte-to-word addressing and read-modify-write for partial stores.
module mem_arbiter #(
    parameter int MEM_WORDS = 1024
) (
    input logic          clock,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    localparam logic [2:0] IDLE = 3'd0, READ = 3'd1, CAPTURE = 3'd2, WRITE = 3'd3, DONE = 3'd4;
    logic [2:0]  state_q, state_d, grant_state;
    logic        port_q, port_d, last_q, last_d, we_q, we_d, err_q, err_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d, if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    logic [31:0] mem_ain_q, mem_ain_d, mem_din_q, mem_din_d;
    logic        sel, bad, st_we;
    logic [31:0] addr, mask;
    always_comb begin
        sel = (bus.if_req && bus.d_req) ? !last_q : bus.d_req;
        addr = sel ? bus.d_addr : bus.if_addr;
        bad = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'(MEM_WORDS));
        st_we = sel && bus.d_we;
        grant_state = bad ? DONE : !st_we ? READ : bus.d_be == 4'hF ? WRITE : bus.d_be == 4'h0 ? DONE : READ;
        mask = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
        state_d = state_q;
        port_d = port_q;
        last_d = last_q;
        we_d = we_q;
        be_d = be_q;
        err_d = err_q;
        wdata_d = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d = d_rdata_q;
        mem_ain_d = mem_ain_q;
        mem_din_d = mem_din_q;
        if (state_q == IDLE) begin
            if (bus.if_req || bus.d_req) begin
                state_d = grant_state;
                port_d = sel;
                last_d = sel;
                we_d = st_we;
                be_d = bus.d_be;
                err_d = bad;
                wdata_d = bus.d_wdata;
                mem_ain_d = (grant_state == READ || grant_state == WRITE) ? {2'b00, addr[31:2]} : mem_ain_q;
                mem_din_d = (grant_state == WRITE) ? bus.d_wdata : mem_din_q;
            end
        end else if (state_q == READ) begin
            state_d = CAPTURE;
        end else if (state_q == CAPTURE) begin
            state_d = we_q ? WRITE : DONE;
            mem_din_d = we_q ? ((wdata_q & mask) | (bus.mem_dout & ~mask)) : mem_din_q;
            if_rdata_d = (!we_q && !port_q) ? bus.mem_dout : if_rdata_q;
            d_rdata_d = (!we_q && port_q) ? bus.mem_dout : d_rdata_q;
        end else if (state_q == WRITE) begin
            state_d = DONE;
        end else begin
            state_d = IDLE;
        end
    end
    // last_q resets to the data port so the first tie goes to fetch
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            port_q <= 1'b0;
            last_q <= 1'b1;
            we_q <= 1'b0;
            be_q <= 4'h0;
            err_q <= 1'b0;
            wdata_q <= '0;
            if_rdata_q <= '0;
            d_rdata_q <= '0;
            mem_ain_q <= '0;
            mem_din_q <= '0;
        end else begin
            state_q <= state_d;
            port_q <= port_d;
            last_q <= last_d;
            we_q <= we_d;
            be_q <= be_d;
            err_q <= err_d;
            wdata_q <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q <= d_rdata_d;
            mem_ain_q <= mem_ain_d;
            mem_din_q <= mem_din_d;
        end
    end
    assign bus.if_ack = (state_q == DONE) && !port_q;
    assign bus.d_ack = (state_q == DONE) && port_q;
    assign bus.if_err = bus.if_ack && err_q;
    assign bus.d_err = bus.d_ack && err_q;
    assign bus.if_rdata = if_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.mem_enable = (state_q == READ) || (state_q == WRITE);
    assign bus.mem_rw = state_q == WRITE;
    assign bus.mem_ain = mem_ain_q;
    assign bus.mem_din = mem_din_q;
    assign bus.busy = state_q != IDLE;
endmodule
